seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles per digit slot (1 kHz per digit at 50 MHz), legal range 2..2^24-1.
REQ-002 SHALL have parameter DEAD, default 500, blank cycles at the start of each slot, legal range 0..SCAN_DIV-1.
REQ-003 SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  scan enable; low forces the display blank.
REQ-006 SHALL have port tick  input  1  one-cycle 1 Hz pulse in the clk domain.
REQ-007 SHALL have ports sec0, sec1, min0, min1  input  8 each  active-low segment codes, bit7 = dp, bit6..0 = g..a.
REQ-008 SHALL have port seg  output  8  active-low segment drive, registered.
REQ-009 SHALL have port dig  output  4  active-low digit enable, registered; bit0 = sec0, bit1 = sec1, bit2 = min0, bit3 = min1.
REQ-010 SHALL have port frame  output  1  one-cycle pulse after each complete 4-digit scan, registered.

Function
REQ-011 SHALL keep slot counter cnt (24 bit, 0..SCAN_DIV-1) and digit index idx (2 bit, 0..3); on each edge with en=1, cnt increments; at cnt=SCAN_DIV-1 it wraps to 0 and idx increments, wrapping 3->0.
REQ-012 SHALL decode state BLANK when cnt<DEAD, else SHOW; DEAD=0 means no BLANK state exists.
REQ-013 SHALL register outputs from the current cnt/idx: BLANK -> seg=8'hFF, dig=4'b1111; SHOW -> dig has only bit idx low and seg=snapshot[idx]; 1-cycle latency from cnt/idx to pins.
REQ-014 SHALL load all four inputs into snapshot registers on every edge with en=1, cnt=0 and idx=0; mid-frame input changes SHALL first appear in the next frame (no tearing).
REQ-015 SHALL drive frame=1 for exactly one cycle, on the edge that sees cnt=SCAN_DIV-1 and idx=3 with en=1, and 0 otherwise.
REQ-016 SHALL, on an edge with en=0: set cnt=0, idx=0, seg=8'hFF, dig=4'b1111, frame=0, and hold the snapshot; after en returns high the scan restarts at slot 0 in BLANK.
REQ-017 SHALL never have more than one dig bit low in any cycle.
REQ-018 SHALL give reset priority over en and tick when they occur on the same edge.

Reset
REQ-019 SHALL, on an edge with reset=1: set cnt=0, idx=0, all snapshot registers=8'hFF, seg=8'hFF, dig=4'b1111, frame=0, and blink toggle=0.
REQ-020 SHALL blank the outputs on the first edge of a reset asserted mid-SHOW, and restart at slot 0 in BLANK after release.

Configuration
REQ-021 SHALL, with macro SEG_SCAN_DP_BLINK_EN defined, keep a toggle register that flips on each edge with tick=1, and force min0 dp (seg[7] in the idx=2 SHOW slot) to ~toggle (lit when toggle=1), overriding the snapshot bit7.
REQ-022 SHALL, without SEG_SCAN_DP_BLINK_EN, contain no toggle register, ignore tick, and pass snapshot bit7 through unchanged.

Verification (SCAN_DIV=8, DEAD=2; edge n = nth edge after reset release, en=1)
REQ-023 SHALL cover reset held 5 cycles with arbitrary inputs -> seg=FF, dig=1111, frame=0 on every cycle.
REQ-024 SHALL cover sec0=C0, sec1=F9, min0=A4, min1=B0 -> edges 1-2 blank; edges 3-8 dig=1110, seg=C0; edges 9-10 blank; edges 11-16 dig=1101, seg=F9; edges 19-24 dig=1011, seg=A4; edges 27-32 dig=0111, seg=B0; frame=1 only after edge 32.
REQ-025 SHALL cover sec0 changed C0->99 at edge 12 -> frame 1 shows C0; edges 35-40 show dig=1110, seg=99.
REQ-026 SHALL cover en=0 at edge 20 for 3 cycles -> blank, frame=0; on re-enable, 2 blank edges then dig=1110 with the held snapshot.
REQ-027 SHALL cover reset asserted at edge 5 (SHOW) -> blank at that edge; after release, the edge 1-8 sequence repeats with snapshot reloaded.
REQ-028 SHALL cover, with SEG_SCAN_DP_BLINK_EN defined and min0=A4, tick at edge 4 -> seg=24 in the idx=2 slot; a second tick returns it to A4; without the macro it stays A4.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a 4-digit active-low 7-segment display with a dead-time blank
// at the start of each digit slot. Optional min0 dp blink is enabled by SEG_SCAN_DP_BLINK_EN.
module seg_scan_driver #(
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned DEAD     = 500
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       tick,
   input  logic [7:0] sec0,
   input  logic [7:0] sec1,
   input  logic [7:0] min0,
   input  logic [7:0] min1,
   output logic [7:0] seg,
   output logic [3:0] dig,
   output logic       frame
);

   localparam logic [23:0] CntLast = 24'(SCAN_DIV - 1);
   localparam logic [23:0] DeadCnt = 24'(DEAD);

   typedef enum logic {StBlank, StShow} state_e;

   logic [23:0]     cnt_q, cnt_d;
   logic [1:0]      idx_q, idx_d;
   logic [3:0][7:0] snap_q, snap_d;
   logic [7:0]      seg_d;
   logic [3:0]      dig_d;
   logic            frame_d;
   logic            load;
   state_e          state;

   assign state = (cnt_q < DeadCnt) ? StBlank : StShow;
   assign load  = en && (cnt_q == 24'd0) && (idx_q == 2'd0);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= 24'd0;
         idx_q  <= 2'd0;
         snap_q <= {4{8'hFF}};
         seg    <= 8'hFF;
         dig    <= 4'b1111;
         frame  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         snap_q <= snap_d;
         seg    <= seg_d;
         dig    <= dig_d;
         frame  <= frame_d;
      end
   end

   // Next-state logic
   always_comb begin
      cnt_d  = cnt_q;
      idx_d  = idx_q;
      snap_d = snap_q;
      if (!en) begin
         cnt_d = 24'd0;
         idx_d = 2'd0;
      end else if (cnt_q == CntLast) begin
         cnt_d = 24'd0;
         idx_d = idx_q + 2'd1;
      end else begin
         cnt_d = cnt_q + 24'd1;
      end
      if (load) begin
         snap_d = {min1, min0, sec1, sec0};
      end
   end

`ifdef SEG_SCAN_DP_BLINK_EN
   logic toggle_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         toggle_q <= 1'b0;
      end else if (tick) begin
         toggle_q <= ~toggle_q;
      end
   end
`else
   logic unused_tick;
   assign unused_tick = tick;
`endif

   // Output decode; snap_d bypasses the load so a DEAD=0 first slot shows fresh data
   always_comb begin
      seg_d   = 8'hFF;
      dig_d   = 4'b1111;
      frame_d = 1'b0;
      if (en) begin
         frame_d = (cnt_q == CntLast) && (idx_q == 2'd3);
         if (state == StShow) begin
            dig_d[idx_q] = 1'b0;
            seg_d        = snap_d[idx_q];
`ifdef SEG_SCAN_DP_BLINK_EN
            if (idx_q == 2'd2) begin
               seg_d[7] = ~toggle_q;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=8, DEAD=2: a table-driven two-frame scan
// plus hand-written enable-drop, mid-SHOW reset and dp blink sequences.
module tb_seg_scan_driver;

   logic       clk = 1'b0;
   logic       reset, en, tick;
   logic [7:0] sec0, sec1, min0, min1;
   logic [7:0] seg;
   logic [3:0] dig;
   logic       frame;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;

   seg_scan_driver #(
      .SCAN_DIV(8),
      .DEAD    (2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .en   (en),
      .tick (tick),
      .sec0 (sec0),
      .sec1 (sec1),
      .min0 (min0),
      .min1 (min1),
      .seg  (seg),
      .dig  (dig),
      .frame(frame)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         first;
      int         last;
      logic [7:0] seg;
      logic [3:0] dig;
      logic       frame;
   } vec_t;

   vec_t tbl[12];

   // At most one digit enabled in any cycle
   always @(negedge clk) begin
      if (!$isunknown(dig)) begin
         checks++;
         if ($countones(~dig) > 1) begin
            errors++;
            $display("FAIL one_digit t=%0t: dig=%b, required at most one low bit", $time, dig);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic check(input string name, input logic [7:0] es, input logic [3:0] ed,
                        input logic ef);
      checks++;
      if (seg !== es || dig !== ed || frame !== ef) begin
         errors++;
         $display("FAIL %s edge %0d: seg=%h dig=%b frame=%b, required seg=%h dig=%b frame=%b",
                  name, edge_n, seg, dig, frame, es, ed, ef);
      end
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         step();
         check("reset", 8'hFF, 4'b1111, 1'b0);
      end
      reset  = 1'b0;
      edge_n = 0;
   endtask

   task automatic run_to(input int n);
      while (edge_n < n) step();
   endtask

   logic [7:0] dp_exp;

   initial begin
      tbl[0]  = '{1, 2, 8'hFF, 4'b1111, 1'b0};
      tbl[1]  = '{3, 8, 8'hC0, 4'b1110, 1'b0};
      tbl[2]  = '{9, 10, 8'hFF, 4'b1111, 1'b0};
      tbl[3]  = '{11, 16, 8'hF9, 4'b1101, 1'b0};
      tbl[4]  = '{17, 18, 8'hFF, 4'b1111, 1'b0};
      tbl[5]  = '{19, 24, 8'hA4, 4'b1011, 1'b0};
      tbl[6]  = '{25, 26, 8'hFF, 4'b1111, 1'b0};
      tbl[7]  = '{27, 31, 8'hB0, 4'b0111, 1'b0};
      tbl[8]  = '{32, 32, 8'hB0, 4'b0111, 1'b1};
      tbl[9]  = '{33, 34, 8'hFF, 4'b1111, 1'b0};
      tbl[10] = '{35, 40, 8'h99, 4'b1110, 1'b0};
      tbl[11] = '{41, 42, 8'hFF, 4'b1111, 1'b0};

      // Reset held 5 cycles with arbitrary inputs
      reset = 1'b1; en = 1'b1; tick = 1'b1;
      sec0 = 8'h12; sec1 = 8'h34; min0 = 8'h56; min1 = 8'h78;
      do_reset(5);
      tick = 1'b0;

      // Two full frames; sec0 changes mid-frame and must wait for frame 2
      sec0 = 8'hC0; sec1 = 8'hF9; min0 = 8'hA4; min1 = 8'hB0;
      do_reset(1);
      for (int i = 0; i < 12; i++) begin
         for (int e = tbl[i].first; e <= tbl[i].last; e++) begin
            step();
            check("scan", tbl[i].seg, tbl[i].dig, tbl[i].frame);
            if (edge_n == 12) sec0 = 8'h99;
         end
      end

      // Enable dropped for edges 20-22
      sec0 = 8'hC0;
      do_reset(1);
      run_to(19);
      check("pre_disable", 8'hA4, 4'b1011, 1'b0);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("disabled", 8'hFF, 4'b1111, 1'b0);
      end
      en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         check("reenable_blank", 8'hFF, 4'b1111, 1'b0);
      end
      for (int i = 0; i < 6; i++) begin
         step();
         check("reenable_show", 8'hC0, 4'b1110, 1'b0);
      end

      // Reset asserted in SHOW at edge 5, snapshot reloaded after release
      do_reset(1);
      run_to(4);
      check("pre_reset_show", 8'hC0, 4'b1110, 1'b0);
      sec0 = 8'hF9;
      reset = 1'b1;
      step();
      check("mid_reset", 8'hFF, 4'b1111, 1'b0);
      reset = 1'b0;
      edge_n = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (edge_n <= 2) check("post_reset_blank", 8'hFF, 4'b1111, 1'b0);
         else check("post_reset_show", 8'hF9, 4'b1110, 1'b0);
      end

      // dp blink on min0 slot
`ifdef SEG_SCAN_DP_BLINK_EN
      dp_exp = 8'h24;
`else
      dp_exp = 8'hA4;
`endif
      sec0 = 8'hC0;
      do_reset(1);
      run_to(3);
      tick = 1'b1;
      step();
      tick = 1'b0;
      run_to(19);
      check("dp_after_tick1", dp_exp, 4'b1011, 1'b0);
      run_to(24);
      check("dp_slot_end", dp_exp, 4'b1011, 1'b0);
      tick = 1'b1;
      step();
      tick = 1'b0;
      run_to(51);
      check("dp_after_tick2", 8'hA4, 4'b1011, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
